uc_sequencer: RTL and testbench
===============================

// Module: uc_sequencer
// PURPOSE
//  Multicycle control unit for the microc datapath; replaces bench-driven control signals.
//  Latches the 16-bit instruction word, decodes opcode = instr[15:10].
//  Each instruction takes 2 cycles (DECODE, EXEC). In EXEC it drives s_inc, s_skip, s_inm, we, ALUOp and pc_en.
//  Detects the JR +0 end-of-program idiom and halts.
// PARAMETERS
//  HALT_ON_SELFJUMP  1  1: JR with offset 0 enters HALT; 0: executes as a normal jump.
//  ILLEGAL_HALT      0  1: illegal opcode enters HALT after its NOP EXEC; 0: continue.
// PORTS
//  clk      in   1   system clock, rising edge
//  reset    in   1   synchronous, active-high; all state cleared on the edge it is sampled
//  start    in   1   level/pulse; sampled only in IDLE
//  instr    in   16  current instruction word from datapath ROM (opcode [15:10], JR offset [9:0])
//  zero     in   1   ALU zero flag (combinational, valid in EXEC)
//  carry    in   1   ALU carry flag (combinational, valid in EXEC)
//  pc_en    out  1   PC register update enable
//  s_inc    out  1   1: PC+1/PC+2 path; 0: PC+offset (JR)
//  s_skip   out  1   1: PC+2 (skip taken)
//  s_inm    out  1   1: regfile write data from immediate
//  we       out  1   regfile write enable
//  ALUOp    out  3   ALU operation
//  busy     out  1   1 in DECODE/EXEC
//  halted   out  1   1 in HALT
//  illegal  out  1   sticky: illegal opcode executed since reset
// BEHAVIOUR
//  States: IDLE, DECODE, EXEC, HALT. Reset -> IDLE; all outputs 0, ALUOp=000, ir=0.
//  IDLE: outputs 0. start=1 -> DECODE.
//  DECODE: ir <= instr. pc_en=we=s_inc=s_skip=s_inm=0, ALUOp=000. Next state: EXEC.
//  EXEC: pc_en=1; drive controls from ir per the decode table. Next state: DECODE, or HALT per below.
//  Decode table (opcode = ir[15:10]):
//   00xxxx LI:     we=1 s_inm=1 s_inc=1 s_skip=0 ALUOp=000
//   100aaa ALU:    we=1 s_inm=0 s_inc=1 s_skip=0 ALUOp=aaa
//   111100 SKIPNE: we=0 s_inc=1 ALUOp=011 s_skip=~zero
//   111101 SKIPEQ: we=0 s_inc=1 ALUOp=011 s_skip=zero
//   111110 SKIPC:  we=0 s_inc=1 ALUOp=010 s_skip=carry
//   111111 JR:     we=0 s_inc=0 s_skip=0 ALUOp=000
//   all other opcodes: NOP (we=0 s_inc=1 s_skip=0 ALUOp=000); illegal <= 1 at the end of EXEC.
//  Skip flags are sampled combinationally in EXEC; no flag registers.
//  JR with ir[9:0]==0 and HALT_ON_SELFJUMP=1: EXEC still drives pc_en=1 (PC unchanged), then HALT.
//  Illegal opcode with ILLEGAL_HALT=1: NOP EXEC, then HALT.
//  HALT: all control outputs 0, halted=1. Exit only by reset; start is ignored.
//  start while busy or halted: ignored. Throughput: 1 instruction per 2 cycles.
//  Reset mid-instruction (any state): next state IDLE, outputs 0, illegal=0; no partial write.
// CONFIGURATION
//  UC_ICOUNT_EN defined: adds output icount[15:0].
//   icount increments at the end of every EXEC, including NOP and the halting JR.
//   It wraps 0xFFFF->0x0000, is cleared by reset and holds in HALT.
//  UC_ICOUNT_EN undefined: port and counter are absent; behaviour otherwise identical.
// TESTING
//  1. reset; start=1 with instr=0x0011 (LI #1,R1) -> DECODE: all 0; EXEC: we=1 s_inm=1 s_inc=1 pc_en=1 ALUOp=000.
//  2. instr=0xF131 (SKIPNE): zero=0 -> EXEC s_skip=1 ALUOp=011 we=0; repeat with zero=1 -> s_skip=0.
//  3. instr=0x8800 (ALU aaa=010) -> EXEC ALUOp=010 we=1 s_inm=0; instr=0xF800 (SKIPC) with carry=1 -> s_skip=1.
//  4. instr=0xFFFC (JR -4) -> EXEC s_inc=0 pc_en=1, then DECODE.
//     instr=0xFC00 (JR +0) -> HALT; halted=1, controls stay 0 for 10 cycles; start pulse ignored.
//  5. instr=0x4000 (illegal) -> EXEC NOP, illegal=1 and sticky.
//     With ILLEGAL_HALT=1 -> halted=1 one cycle after that EXEC.
//  6. reset during EXEC of an LI -> next cycle IDLE, we=0, illegal=0.
//     With UC_ICOUNT_EN: run 3 instructions -> icount=3; after reset -> 0.

Source files
------------

// File: rtl/uc_sequencer.sv
// Two-cycle (DECODE/EXEC) control sequencer for the microc datapath, with halt on the JR +0 idiom.
// Optional build macro UC_ICOUNT_EN adds a 16-bit retired-instruction counter output, icount.
module uc_sequencer #(
    parameter bit HALT_ON_SELFJUMP = 1'b1,
    parameter bit ILLEGAL_HALT     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic        zero,
    input  logic        carry,
    output logic        pc_en,
    output logic        s_inc,
    output logic        s_skip,
    output logic        s_inm,
    output logic        we,
    output logic [2:0]  ALUOp,
    output logic        busy,
    output logic        halted,
`ifdef UC_ICOUNT_EN
    output logic [15:0] icount,
`endif
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, HALT} state_t;

    typedef struct packed {
        logic       we;
        logic       inm;
        logic       inc;
        logic [2:0] alu_op;
        logic       sk_ne;
        logic       sk_eq;
        logic       sk_c;
    } ctl_t;

    function automatic logic is_legal(input logic [5:0] op);
        casez (op)
            6'b00????, 6'b100???, 6'b1111??: is_legal = 1'b1;
            default:                         is_legal = 1'b0;
        endcase
    endfunction

    // Illegal opcodes fall through to the NOP default (inc=1, nothing written).
    function automatic ctl_t decode(input logic [5:0] op);
        ctl_t c;
        c     = '0;
        c.inc = 1'b1;
        casez (op)
            6'b00????: begin c.we = 1'b1; c.inm = 1'b1; end
            6'b100???: begin c.we = 1'b1; c.alu_op = op[2:0]; end
            6'b111100: begin c.alu_op = 3'b011; c.sk_ne = 1'b1; end
            6'b111101: begin c.alu_op = 3'b011; c.sk_eq = 1'b1; end
            6'b111110: begin c.alu_op = 3'b010; c.sk_c  = 1'b1; end
            6'b111111: c.inc = 1'b0;
            default:   ;
        endcase
        return c;
    endfunction

    state_t      state;
    logic [15:0] ir;
    logic        skip_ne, skip_eq, skip_c;
    ctl_t        dc;
    logic        halt_now;

    assign dc = decode(instr[15:10]);

    // The halting decision is made from the latched word, not the live ROM output.
    assign halt_now = (HALT_ON_SELFJUMP && (&ir[15:10]) && (ir[9:0] == 10'd0)) ||
                      (ILLEGAL_HALT && !is_legal(ir[15:10]));

    // Flags are consumed live during EXEC; only the selection is registered.
    assign s_skip = (skip_ne & ~zero) | (skip_eq & zero) | (skip_c & carry);

    // NOTE: every register here is updated with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ir      <= '0;
            pc_en   <= 1'b0;
            we      <= 1'b0;
            s_inm   <= 1'b0;
            s_inc   <= 1'b0;
            ALUOp   <= 3'b000;
            skip_ne <= 1'b0;
            skip_eq <= 1'b0;
            skip_c  <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
`ifdef UC_ICOUNT_EN
            icount  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DECODE;
                        busy  <= 1'b1;
                    end
                end
                DECODE: begin
                    ir      <= instr;
                    state   <= EXEC;
                    pc_en   <= 1'b1;
                    we      <= dc.we;
                    s_inm   <= dc.inm;
                    s_inc   <= dc.inc;
                    ALUOp   <= dc.alu_op;
                    skip_ne <= dc.sk_ne;
                    skip_eq <= dc.sk_eq;
                    skip_c  <= dc.sk_c;
                end
                EXEC: begin
                    pc_en   <= 1'b0;
                    we      <= 1'b0;
                    s_inm   <= 1'b0;
                    s_inc   <= 1'b0;
                    ALUOp   <= 3'b000;
                    skip_ne <= 1'b0;
                    skip_eq <= 1'b0;
                    skip_c  <= 1'b0;
                    illegal <= illegal | ~is_legal(ir[15:10]);
`ifdef UC_ICOUNT_EN
                    icount  <= icount + 16'd1;
`endif
                    if (halt_now) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state  <= DECODE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed self-checking bench for uc_sequencer; a second instance runs with ILLEGAL_HALT=1, HALT_ON_SELFJUMP=0.
// Optional build macro UC_ICOUNT_EN enables the icount checks.
module tb_uc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        zero = 1'b0;
    logic        carry = 1'b0;

    logic        pc_en, s_inc, s_skip, s_inm, we, busy, halted, illegal;
    logic [2:0]  ALUOp;
    logic        pc_en2, s_inc2, s_skip2, s_inm2, we2, busy2, halted2, illegal2;
    logic [2:0]  ALUOp2;
`ifdef UC_ICOUNT_EN
    logic [15:0] icount, icount2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uc_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .zero(zero), .carry(carry),
        .pc_en(pc_en), .s_inc(s_inc), .s_skip(s_skip), .s_inm(s_inm), .we(we), .ALUOp(ALUOp),
        .busy(busy), .halted(halted),
`ifdef UC_ICOUNT_EN
        .icount(icount),
`endif
        .illegal(illegal)
    );

    uc_sequencer #(.HALT_ON_SELFJUMP(1'b0), .ILLEGAL_HALT(1'b1)) dut_ih (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .zero(zero), .carry(carry),
        .pc_en(pc_en2), .s_inc(s_inc2), .s_skip(s_skip2), .s_inm(s_inm2), .we(we2), .ALUOp(ALUOp2),
        .busy(busy2), .halted(halted2),
`ifdef UC_ICOUNT_EN
        .icount(icount2),
`endif
        .illegal(illegal2)
    );

    // Observed vector: {pc_en, we, s_inm, s_inc, s_skip, ALUOp, busy, halted, illegal}
    function automatic logic [10:0] obs();
        return {pc_en, we, s_inm, s_inc, s_skip, ALUOp, busy, halted, illegal};
    endfunction

    function automatic logic [10:0] obs2();
        return {pc_en2, we2, s_inm2, s_inc2, s_skip2, ALUOp2, busy2, halted2, illegal2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (obs() !== 11'b00000_000_000) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 11'b00000_000_000);
        end
        checks++;
        if (obs2() !== 11'b00000_000_000) begin
            errors++; $display("FAIL reset_outputs_ih got=%b exp=%b", obs2(), 11'b00000_000_000);
        end
        tick();
        checks++;
        if (obs() !== 11'b00000_000_000) begin
            errors++; $display("FAIL idle_no_start got=%b exp=%b", obs(), 11'b00000_000_000);
        end
`ifdef UC_ICOUNT_EN
        checks++;
        if (icount !== 16'd0) begin
            errors++; $display("FAIL reset_icount got=%0d exp=0", icount);
        end
`endif
    endtask

    task automatic test_li();
        start = 1'b1;
        instr = 16'h0011;
        tick();
        start = 1'b0;
        checks++;
        if (obs() !== 11'b00000_000_100) begin
            errors++; $display("FAIL li_decode got=%b exp=%b", obs(), 11'b00000_000_100);
        end
        tick();
        checks++;
        if (obs() !== 11'b11110_000_100) begin
            errors++; $display("FAIL li_exec got=%b exp=%b", obs(), 11'b11110_000_100);
        end
    endtask

    task automatic test_skip();
        instr = 16'hF131;
        zero  = 1'b0;
        tick();
        checks++;
        if (obs() !== 11'b00000_000_100) begin
            errors++; $display("FAIL skipne_decode got=%b exp=%b", obs(), 11'b00000_000_100);
        end
        tick();
        checks++;
        if (obs() !== 11'b10011_011_100) begin
            errors++; $display("FAIL skipne_zero0 got=%b exp=%b", obs(), 11'b10011_011_100);
        end
        zero = 1'b1;
        #1;
        checks++;
        if (obs() !== 11'b10010_011_100) begin
            errors++; $display("FAIL skipne_zero1 got=%b exp=%b", obs(), 11'b10010_011_100);
        end
        instr = 16'hF400;
        tick();
        tick();
        checks++;
        if (obs() !== 11'b10011_011_100) begin
            errors++; $display("FAIL skipeq_zero1 got=%b exp=%b", obs(), 11'b10011_011_100);
        end
        zero = 1'b0;
        #1;
        checks++;
        if (obs() !== 11'b10010_011_100) begin
            errors++; $display("FAIL skipeq_zero0 got=%b exp=%b", obs(), 11'b10010_011_100);
        end
    endtask

    task automatic test_alu_skipc();
        instr = 16'h8800;
        carry = 1'b1;
        tick();
        tick();
        checks++;
        if (obs() !== 11'b11010_010_100) begin
            errors++; $display("FAIL alu_exec got=%b exp=%b", obs(), 11'b11010_010_100);
        end
        instr = 16'hF800;
        tick();
        tick();
        checks++;
        if (obs() !== 11'b10011_010_100) begin
            errors++; $display("FAIL skipc_carry1 got=%b exp=%b", obs(), 11'b10011_010_100);
        end
        carry = 1'b0;
        #1;
        checks++;
        if (obs() !== 11'b10010_010_100) begin
            errors++; $display("FAIL skipc_carry0 got=%b exp=%b", obs(), 11'b10010_010_100);
        end
    endtask

    task automatic test_jr_halt();
        instr = 16'hFFFC;
        tick();
        tick();
        checks++;
        if (obs() !== 11'b10000_000_100) begin
            errors++; $display("FAIL jr_exec got=%b exp=%b", obs(), 11'b10000_000_100);
        end
        instr = 16'hFC00;
        tick();
        checks++;
        if (obs() !== 11'b00000_000_100) begin
            errors++; $display("FAIL jr_then_decode got=%b exp=%b", obs(), 11'b00000_000_100);
        end
        tick();
        checks++;
        if (obs() !== 11'b10000_000_100) begin
            errors++; $display("FAIL jr0_exec got=%b exp=%b", obs(), 11'b10000_000_100);
        end
        tick();
        checks++;
        if (obs() !== 11'b00000_000_010) begin
            errors++; $display("FAIL jr0_halt got=%b exp=%b", obs(), 11'b00000_000_010);
        end
        checks++;
        if ({busy2, halted2} !== 2'b10) begin
            errors++; $display("FAIL jr0_no_halt_ih got=%b exp=10", {busy2, halted2});
        end
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            tick();
            checks++;
            if (obs() !== 11'b00000_000_010) begin
                errors++; $display("FAIL halt_hold cycle=%0d got=%b exp=%b", i, obs(), 11'b00000_000_010);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_illegal();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        instr = 16'h4000;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (obs() !== 11'b10010_000_100) begin
            errors++; $display("FAIL illegal_exec got=%b exp=%b", obs(), 11'b10010_000_100);
        end
        checks++;
        if (obs2() !== 11'b10010_000_100) begin
            errors++; $display("FAIL illegal_exec_ih got=%b exp=%b", obs2(), 11'b10010_000_100);
        end
        instr = 16'h0011;
        tick();
        checks++;
        if (obs() !== 11'b00000_000_101) begin
            errors++; $display("FAIL illegal_flag got=%b exp=%b", obs(), 11'b00000_000_101);
        end
        checks++;
        if (obs2() !== 11'b00000_000_011) begin
            errors++; $display("FAIL illegal_halt_ih got=%b exp=%b", obs2(), 11'b00000_000_011);
        end
        tick();
        checks++;
        if (obs() !== 11'b11110_000_101) begin
            errors++; $display("FAIL illegal_sticky got=%b exp=%b", obs(), 11'b11110_000_101);
        end
        checks++;
        if (obs2() !== 11'b00000_000_011) begin
            errors++; $display("FAIL illegal_halt_hold_ih got=%b exp=%b", obs2(), 11'b00000_000_011);
        end
`ifdef UC_ICOUNT_EN
        checks++;
        if (icount2 !== 16'd1) begin
            errors++; $display("FAIL icount_hold_halt got=%0d exp=1", icount2);
        end
`endif
    endtask

    // Entered with dut in EXEC of an LI.
    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (obs() !== 11'b00000_000_000) begin
            errors++; $display("FAIL reset_mid_exec got=%b exp=%b", obs(), 11'b00000_000_000);
        end
`ifdef UC_ICOUNT_EN
        checks++;
        if (icount !== 16'd0) begin
            errors++; $display("FAIL reset_mid_icount got=%0d exp=0", icount);
        end
`endif
        tick();
        checks++;
        if (obs() !== 11'b00000_000_000) begin
            errors++; $display("FAIL reset_mid_idle got=%b exp=%b", obs(), 11'b00000_000_000);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        instr = 16'h0011;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== 11'b11110_000_100) begin
                errors++; $display("FAIL b2b_exec n=%0d got=%b exp=%b", i, obs(), 11'b11110_000_100);
            end
            tick();
        end
`ifdef UC_ICOUNT_EN
        checks++;
        if (icount !== 16'd3) begin
            errors++; $display("FAIL icount_three got=%0d exp=3", icount);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (icount !== 16'd0) begin
            errors++; $display("FAIL icount_reset got=%0d exp=0", icount);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_li();
        test_skip();
        test_alu_skipc();
        test_jr_halt();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
